// File: rtl/mram_be_wbuf_ctrl.sv
// -----------------------------------------------------------------------------
// mram_be_wbuf_ctrl
//   Access controller in front of one single-port byte-enable SRAM macro.
//   A unified read/write request stream is split so that writes are parked
//   in a small FIFO write buffer and drained onto the SRAM port whenever it is
//   not needed by a read. Reads win the port unless the buffer is full. A read
//   whose address matches any buffered write is held off until that write has
//   drained. Read data is bypassed from SRAM DOUT in the cycle it is valid and
//   captured in a hold register so it stays stable under response backpressure.
//
// Ports
//   clk_i, rst_ni            clock (posedge), asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i                 byte write mask, all-zero means read
//   req_addr_i, req_wdat_i   word address and write data
//   rsp_valid_o/rsp_ready_i  read response handshake
//   rsp_data_o               read data
//   wb_empty_o               buffer empty and no SRAM write this cycle
//   sram_addr_o, sram_re_o,
//   sram_we_o, sram_din_o    SRAM macro controls
//   sram_dout_i              SRAM read data, valid the cycle after sram_re_o
//
// Build option
//   NCPU_WBUF_MERGE_EN : when defined, a write to the same address as the
//   newest buffered entry (that is not being drained this cycle) is merged
//   into that entry instead of allocating a new one.
// -----------------------------------------------------------------------------
module mram_be_wbuf_ctrl #(
  parameter int P_DW       = 6,
  parameter int AW         = 6,
  parameter int WB_P_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [((1<<P_DW)/8)-1:0]      req_we_i,
  input  logic [AW-1:0]                 req_addr_i,
  input  logic [(1<<P_DW)-1:0]          req_wdat_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [(1<<P_DW)-1:0]          rsp_data_o,
  output logic                          wb_empty_o,
  output logic [AW-1:0]                 sram_addr_o,
  output logic                          sram_re_o,
  output logic [((1<<P_DW)/8)-1:0]      sram_we_o,
  output logic [(1<<P_DW)-1:0]          sram_din_o,
  input  logic [(1<<P_DW)-1:0]          sram_dout_i
);

  localparam int DW    = 1 << P_DW;
  localparam int BYTES = DW / 8;
  localparam int DEPTH = 1 << WB_P_DEPTH;
  localparam int PW    = WB_P_DEPTH;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] ZERO_C  = (PW+1)'(0);

  // Write buffer storage and pointers
  logic [AW-1:0]    ent_addr_q [DEPTH];
  logic [BYTES-1:0] ent_we_q   [DEPTH];
  logic [DW-1:0]    ent_wdat_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;

  // Response state: rsp_pend_q marks the cycle SRAM DOUT carries our data
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic [DW-1:0]    hold_q, hold_d;

  logic is_wr_s, full_s, hazard_s, rsp_free_s;
  logic rd_go_s, push_s, merge_s, drain_s;
`ifdef NCPU_WBUF_MERGE_EN
  logic [PW-1:0] tail_m1_s;
`endif

  // Address match of the incoming request against every occupied buffer slot
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count_q) && (ent_addr_q[rd_ptr_q + PW'(i)] == req_addr_i)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Request decode, port arbitration and next-state computation
  always_comb begin
    is_wr_s    = |req_we_i;
    full_s     = (count_q == DEPTH_C);
    rsp_free_s = !rsp_valid_q || rsp_ready_i;

`ifdef NCPU_WBUF_MERGE_EN
    tail_m1_s = wr_ptr_q - PW'(1);
    // With two or more entries the newest one can never be the head being
    // drained this cycle, so merging into it is always safe.
    merge_s   = rst_ni && req_valid_i && is_wr_s && (count_q > (PW+1)'(1)) &&
                (ent_addr_q[tail_m1_s] == req_addr_i);
`else
    merge_s   = 1'b0;
`endif

    rd_go_s = rst_ni && req_valid_i && !is_wr_s && !hazard_s && rsp_free_s && !full_s;
    push_s  = rst_ni && req_valid_i && is_wr_s && !full_s && !merge_s;
    // A full buffer always drains; otherwise a read takes the port first
    drain_s = rst_ni && (count_q != ZERO_C) && (full_s || !rd_go_s);

    rd_ptr_d = drain_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    wr_ptr_d = push_s  ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    count_d  = count_q + (PW+1)'(push_s) - (PW+1)'(drain_s);

    rsp_pend_d = rd_go_s;
    if (rd_go_s) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    hold_d = rsp_pend_q ? sram_dout_i : hold_q;

    req_ready_o = is_wr_s ? (push_s || merge_s) : rd_go_s;
    sram_re_o   = rd_go_s;
    sram_we_o   = drain_s ? ent_we_q[rd_ptr_q] : {BYTES{1'b0}};
    sram_addr_o = rd_go_s ? req_addr_i : ent_addr_q[rd_ptr_q];
    sram_din_o  = ent_wdat_q[rd_ptr_q];
    rsp_valid_o = rsp_valid_q;
    rsp_data_o  = rsp_pend_q ? sram_dout_i : hold_q;
    wb_empty_o  = (count_q == ZERO_C) && !drain_s;
  end

  // Control and response state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= {PW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      count_q     <= ZERO_C;
      rsp_valid_q <= 1'b0;
      rsp_pend_q  <= 1'b0;
      hold_q      <= {DW{1'b0}};
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pend_q  <= rsp_pend_d;
      hold_q      <= hold_d;
    end
  end

  // Buffer entry storage: allocate at the tail, or merge into the newest entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= {AW{1'b0}};
        ent_we_q[i]   <= {BYTES{1'b0}};
        ent_wdat_q[i] <= {DW{1'b0}};
      end
    end else begin
      if (push_s) begin
        ent_addr_q[wr_ptr_q] <= req_addr_i;
        ent_we_q[wr_ptr_q]   <= req_we_i;
        ent_wdat_q[wr_ptr_q] <= req_wdat_i;
      end
`ifdef NCPU_WBUF_MERGE_EN
      else if (merge_s) begin
        ent_we_q[tail_m1_s] <= ent_we_q[tail_m1_s] | req_we_i;
        for (int b = 0; b < BYTES; b++) begin
          if (req_we_i[b]) begin
            ent_wdat_q[tail_m1_s][8*b +: 8] <= req_wdat_i[8*b +: 8];
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mram_be_wbuf_ctrl.sv
module tb_mram_be_wbuf_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_we;
  logic [5:0]  req_addr;
  logic [63:0] req_wdat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        wb_empty;
  logic [5:0]  sram_addr;
  logic        sram_re;
  logic [7:0]  sram_we;
  logic [63:0] sram_din;
  logic [63:0] sram_dout;

  always #5 clk = ~clk;

  mram_be_wbuf_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdat_i  (req_wdat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .wb_empty_o  (wb_empty),
    .sram_addr_o (sram_addr),
    .sram_re_o   (sram_re),
    .sram_we_o   (sram_we),
    .sram_din_o  (sram_din),
    .sram_dout_i (sram_dout)
  );

  typedef struct packed {
    logic [5:0]  a;
    logic [7:0]  we;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];                 // model of buffered writes, oldest first
  logic [63:0] model_mem [64];       // memory as the model says it should be
  logic [63:0] sram_mem  [64];       // the SRAM macro the DUT drives
  logic        exp_rsp_valid;
  logic [63:0] exp_rsp_data;
  int          n_vec  = 0;
  int          n_miss = 0;

  logic [63:0] obs_ready, obs_re, obs_we, obs_addr, obs_rsp_valid, obs_rsp_data;

  function automatic logic [63:0] lane_merge(input logic [63:0] old, input logic [7:0] we,
                                             input logic [63:0] d);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM macro behaviour: write at the edge, DOUT valid only the cycle after RE
  task automatic sram_advance();
    logic [63:0] nd;
    nd = {$urandom, $urandom};
    if (sram_we != 8'h00) sram_mem[sram_addr] = lane_merge(sram_mem[sram_addr], sram_we, sram_din);
    if (sram_re) nd = sram_mem[sram_addr];
    @(posedge clk);
    #1 sram_dout = nd;
  endtask

  task automatic step(input logic v, input logic [7:0] we, input logic [5:0] a,
                      input logic [63:0] d, input logic rr);
    logic is_wr, full, hazard, merge, rd_go, wr_acc, drain;
    ent_t e;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wdat = d; rsp_ready = rr;
    #1;
    is_wr  = (we != 8'h00);
    full   = (q.size() == DEPTH);
    hazard = 1'b0;
    foreach (q[i]) if (q[i].a == a) hazard = 1'b1;
    merge  = 1'b0;
`ifdef NCPU_WBUF_MERGE_EN
    if (v && is_wr && q.size() >= 2 && q[q.size()-1].a == a) merge = 1'b1;
`endif
    rd_go  = v && !is_wr && !hazard && (!exp_rsp_valid || rr) && !full;
    wr_acc = v && is_wr && (!full || merge);
    drain  = (q.size() != 0) && (full || !rd_go);

    if (v) chk("req_ready", 64'(req_ready), 64'(is_wr ? wr_acc : rd_go));
    chk("sram_re", 64'(sram_re), 64'(rd_go));
    chk("sram_we", 64'(sram_we), drain ? 64'(q[0].we) : 64'h0);
    if (rd_go) chk("sram_addr_rd", 64'(sram_addr), 64'(a));
    if (drain) begin
      chk("sram_addr_wr", 64'(sram_addr), 64'(q[0].a));
      chk("sram_din", sram_din, q[0].d);
    end
    chk("wb_empty", 64'(wb_empty), 64'(q.size() == 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
    if (exp_rsp_valid) chk("rsp_data", rsp_data, exp_rsp_data);

    obs_ready = 64'(req_ready); obs_re = 64'(sram_re); obs_we = 64'(sram_we);
    obs_addr = 64'(sram_addr); obs_rsp_valid = 64'(rsp_valid); obs_rsp_data = rsp_data;

    if (rd_go) begin
      exp_rsp_valid = 1'b1;
      exp_rsp_data  = model_mem[a];
    end else if (rr) begin
      exp_rsp_valid = 1'b0;
    end
    if (wr_acc && merge) begin
      q[q.size()-1].we = q[q.size()-1].we | we;
      q[q.size()-1].d  = lane_merge(q[q.size()-1].d, we, d);
    end
    if (drain) begin
      e = q.pop_front();
      model_mem[e.a] = lane_merge(model_mem[e.a], e.we, e.d);
    end
    if (wr_acc && !merge) q.push_back('{a: a, we: we, d: d});
    sram_advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b1; req_we = 8'hFF; req_addr = 6'd0; rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_sram_re", 64'(sram_re), 64'h0);
    chk("rst_sram_we", 64'(sram_we), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_wb_empty", 64'(wb_empty), 64'h1);
    q.delete();
    exp_rsp_valid = 1'b0;
    sram_advance();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] v64;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 8'h00; req_addr = 6'd0; req_wdat = 64'h0;
    rsp_ready = 1'b0; sram_dout = 64'h0; exp_rsp_valid = 1'b0; exp_rsp_data = 64'h0;
    for (int i = 0; i < 64; i++) begin
      v64 = {$urandom, $urandom};
      sram_mem[i] = v64;
      model_mem[i] = v64;
    end
    do_reset();

    // Write, drain on idle, then read back
    step(1'b1, 8'hFF, 6'd5, 64'h1122334455667788, 1'b1);
    chk("t2_wr_ready", obs_ready, 64'h1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    chk("t2_drain_we", obs_we, 64'hFF);
    step(1'b1, 8'h00, 6'd5, 64'h0, 1'b1);
    chk("t2_rd_re", obs_re, 64'h1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    chk("t2_rsp_valid", obs_rsp_valid, 64'h1);
    chk("t2_rsp_data", obs_rsp_data, 64'h1122334455667788);

    // Read-after-write hazard, then a non-matching read overtaking the drain
    step(1'b1, 8'h01, 6'd3, 64'h00000000000000AA, 1'b1);
    step(1'b1, 8'h00, 6'd3, 64'h0, 1'b1);
    chk("t3_hazard_ready", obs_ready, 64'h0);
    chk("t3_hazard_drain", obs_we, 64'h01);
    step(1'b1, 8'h00, 6'd3, 64'h0, 1'b1);
    chk("t3_retry_ready", obs_ready, 64'h1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    chk("t3_rsp_lane0", obs_rsp_data & 64'hFF, 64'hAA);
    step(1'b1, 8'h01, 6'd3, 64'h00000000000000BB, 1'b1);
    step(1'b1, 8'h00, 6'd4, 64'h0, 1'b1);
    chk("t3_rd4_re", obs_re, 64'h1);
    chk("t3_rd4_addr", obs_addr, 64'h4);
    chk("t3_rd4_no_we", obs_we, 64'h0);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    chk("t3_late_drain", obs_we, 64'h01);

    // Four writes then a read: the read takes the port ahead of the last drain
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hFF, 6'(i), 64'(i + 100), 1'b1);
      if (i == 1) chk("t4_drain_addr0", obs_addr, 64'h0);
    end
    step(1'b1, 8'h00, 6'd9, 64'h0, 1'b1);
    chk("t4_rd9_addr", obs_addr, 64'h9);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    chk("t4_drain_addr3", obs_addr, 64'h3);

    // Response backpressure holds data and blocks new reads
    step(1'b1, 8'hFF, 6'd7, 64'hCAFEF00D12345678, 1'b1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    step(1'b1, 8'h00, 6'd7, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00, 6'd6, 64'h0, 1'b0);
      chk("t5_stall_ready", obs_ready, 64'h0);
      chk("t5_stall_re", obs_re, 64'h0);
      chk("t5_hold_data", obs_rsp_data, 64'hCAFEF00D12345678);
    end
    step(1'b1, 8'h00, 6'd6, 64'h0, 1'b1);
    chk("t5_release_ready", obs_ready, 64'h1);
    chk("t5_release_re", obs_re, 64'h1);

    // Two partial writes to one word: final contents combine both halves
    step(1'b1, 8'h0F, 6'd2, 64'hAAAAAAAAAAAAAAAA, 1'b1);
    step(1'b1, 8'hF0, 6'd2, 64'hBBBBBBBBBBBBBBBB, 1'b1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    step(1'b1, 8'h00, 6'd2, 64'h0, 1'b1);
    step(1'b0, 8'h00, 6'd0, 64'h0, 1'b1);
    chk("t6_final_word", obs_rsp_data, 64'hBBBBBBBBAAAAAAAA);

    // Randomized traffic on a narrow address range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic       rv, rw, rr;
      logic [7:0] rwe;
      if (n == 1500) do_reset();
      rv  = ($urandom_range(0, 9) < 8);
      rw  = ($urandom_range(0, 1) == 1);
      rwe = rw ? 8'($urandom_range(1, 255)) : 8'h00;
      rr  = ($urandom_range(0, 3) != 0);
      step(rv, rwe, 6'($urandom_range(0, 7)), {$urandom, $urandom}, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
